// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one registered-read single-port RAM
// between the DHT11 capture writer and the display/UART reader.
module bram_port_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_WAIT,
    RD_DONE
  } state_t;

  state_t state;
  state_t next;
  logic   last_rd;
  logic   both;

  assign both = wr_req & rd_req;

  // last_rd only moves on contention; it picks the loser of the last tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      last_rd <= 1'b1;
    end else begin
      state <= next;
      if (state == IDLE && both)
        last_rd <= ~last_rd;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          both:              next = last_rd ? WR : RD_ADDR;
          wr_req && !rd_req: next = WR;
          rd_req && !wr_req: next = RD_ADDR;
          default:           next = IDLE;
        endcase
      end
      WR:      next = IDLE;
      RD_ADDR: next = RD_WAIT;
      RD_WAIT: next = RD_DONE;
      RD_DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  // outputs are decoded from next so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ack    <= 1'b0;
      rd_ack    <= 1'b0;
      rd_data   <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_din  <= '0;
      busy      <= 1'b0;
    end else begin
      wr_ack  <= (next == WR);
      bram_we <= (next == WR);
      rd_ack  <= (next == RD_DONE);
      busy    <= (next != IDLE);
      if (next == WR) begin
        bram_addr <= wr_addr;
        bram_din  <= wr_data;
      end
      if (next == RD_ADDR)
        bram_addr <= rd_addr;
      if (state == RD_WAIT)
        rd_data <= bram_dout;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed and random traffic against a
// transaction-schedule model of the arbiter plus a behavioural RAM.
module tb_bram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [0:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        rd_req;
  logic [0:0]  rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        bram_we;
  logic [0:0]  bram_addr;
  logic [15:0] bram_din;
  logic [15:0] bram_dout;
  logic        busy;

  bram_port_arbiter #(.DATA_W(16), .ADDR_W(1)) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .bram_dout(bram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [0:1];
  always @(posedge clk) begin
    if (bram_we) ram[bram_addr] <= bram_din;
    bram_dout <= ram[bram_addr];
  end

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // model: one transaction at a time, scheduled by cycle number
  logic [15:0] mm [0:1];
  int          m_idle;
  int          m_wack;
  int          m_rack;
  logic [15:0] m_rpend;
  logic [15:0] m_rdata;
  logic [15:0] m_din;
  logic        m_addr;
  bit          m_last_rd;

  task automatic model_reset();
    m_idle = 0; m_wack = -1; m_rack = -1;
    m_rdata = '0; m_din = '0; m_addr = 1'b0;
    m_rpend = '0; m_last_rd = 1'b1;
  endtask

  task automatic model_edge();
    bit go_w, go_r;
    if (rst) begin
      model_reset();
      return;
    end
    if (cyc < m_idle) return;
    go_w = 1'b0; go_r = 1'b0;
    if (wr_req && rd_req) begin
      go_w = m_last_rd;
      go_r = !m_last_rd;
      m_last_rd = go_r;
    end else begin
      go_w = wr_req;
      go_r = rd_req;
    end
    if (go_w) begin
      m_wack = cyc + 1;
      m_addr = wr_addr;
      m_din = wr_data;
      mm[wr_addr] = wr_data;
      m_idle = cyc + 2;
    end
    if (go_r) begin
      m_addr = rd_addr;
      m_rpend = mm[rd_addr];
      m_rack = cyc + 3;
      m_idle = cyc + 4;
    end
  endtask

  task automatic check_outputs();
    chk("wr_ack", wr_ack, cyc == m_wack);
    chk("bram_we", bram_we, cyc == m_wack);
    chk("rd_ack", rd_ack, cyc == m_rack);
    chk("rd_data", rd_data, m_rdata);
    chk("bram_addr", bram_addr, m_addr);
    chk("bram_din", bram_din, m_din);
    chk("busy", busy, cyc < m_idle);
    chk("one_ack", wr_ack & rd_ack, 0);
  endtask

  // requesters: hold req until ack, then either drop or go again
  int w_left = 0;
  int r_left = 0;
  bit w_seen = 0;
  bit r_seen = 0;

  task automatic service();
    if (w_seen) begin
      w_seen = 0;
      w_left--;
      if (w_left <= 0) wr_req = 1'b0;
      else wr_data = wr_data + 16'd1;
    end
    if (r_seen) begin
      r_seen = 0;
      r_left--;
      if (r_left <= 0) rd_req = 1'b0;
    end
    if (wr_req && wr_ack) w_seen = 1;
    if (rd_req && rd_ack) r_seen = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    if (cyc == m_rack) m_rdata = m_rpend;
    #1;
    check_outputs();
    service();
  endtask

  task automatic start_wr(input logic a, input logic [15:0] d, input int n);
    wr_addr = a; wr_data = d; w_left = n; wr_req = 1'b1;
  endtask

  task automatic start_rd(input logic a, input int n);
    rd_addr = a; r_left = n; rd_req = 1'b1;
  endtask

  task automatic drop_reqs();
    wr_req = 1'b0; rd_req = 1'b0;
    w_left = 0; r_left = 0; w_seen = 0; r_seen = 0;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    model_reset();
    drop_reqs();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drop_reqs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  int t0, n_w, n_r, kind, prev_kind;
  logic [15:0] last_w;
  bit prev_we;

  initial begin
    rst = 1'b1;
    wr_req = 0; wr_addr = 0; wr_data = 0;
    rd_req = 0; rd_addr = 0;
    ram[0] = 16'h1234; ram[1] = 16'hBEEF;
    mm[0] = 16'h1234; mm[1] = 16'hBEEF;
    model_reset();
    do_reset();

    // read-only latency from preloaded RAM
    t0 = cyc; n_r = 0;
    start_rd(1'b0, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rd_ack) begin
        n_r++;
        chk("rd_lat", cyc - t0, 3);
        chk("rd_val", rd_data, 16'h1234);
      end
    end
    chk("rd_cnt", n_r, 1);
    chk("rd_hold", rd_data, 16'h1234);

    // write only, then read back
    t0 = cyc; n_w = 0;
    start_wr(1'b0, 16'h3A19, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (wr_ack) begin
        n_w++;
        chk("wr_lat", cyc - t0, 1);
        chk("wr_din", bram_din, 16'h3A19);
        chk("wr_we", bram_we, 1);
      end
    end
    chk("wr_cnt", n_w, 1);
    t0 = cyc; n_r = 0;
    start_rd(1'b0, 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rd_ack) begin
        n_r++;
        chk("rb_lat", cyc - t0, 3);
        chk("rb_val", rd_data, 16'h3A19);
      end
    end
    chk("rb_cnt", n_r, 1);

    // simultaneous requests after reset: writer wins
    do_reset();
    t0 = cyc;
    start_wr(1'b0, 16'h5501, 1);
    start_rd(1'b0, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (wr_ack) chk("sim_wlat", cyc - t0, 1);
      if (rd_ack) begin
        chk("sim_rlat", cyc - t0, 5);
        chk("sim_rval", rd_data, 16'h5501);
      end
    end

    // continuous contention: W,R,W,R,W,R
    do_reset();
    n_w = 0; n_r = 0; prev_kind = 1; last_w = '0;
    start_wr(1'b1, 16'h0100, 3);
    start_rd(1'b1, 3);
    for (int k = 0; k < 30; k++) begin
      tick();
      if (wr_ack || rd_ack) begin
        kind = rd_ack ? 1 : 0;
        chk("alt", kind, prev_kind ^ 1);
        prev_kind = kind;
      end
      if (wr_ack) begin
        n_w++;
        last_w = wr_data;
      end
      if (rd_ack) begin
        n_r++;
        chk("raw", rd_data, last_w);
      end
    end
    chk("cont_w", n_w, 3);
    chk("cont_r", n_r, 3);

    // reset during RD_WAIT
    start_rd(1'b1, 1);
    tick();
    tick();
    async_reset();
    chk("rst_rdata", rd_data, 0);
    chk("rst_we", bram_we, 0);
    chk("rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    n_r = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rd_ack) n_r++;
    end
    chk("no_ack", n_r, 0);
    start_rd(1'b1, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rd_ack) begin
        n_r++;
        chk("reread", rd_data, 16'h0102);
      end
    end
    chk("reread_cnt", n_r, 1);

    // back-to-back writes
    n_w = 0; prev_we = 0;
    start_wr(1'b0, 16'hA000, 4);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (wr_ack) n_w++;
      chk("we_b2b", prev_we & bram_we, 0);
      prev_we = bram_we;
    end
    chk("b2b_cnt", n_w, 4);

    // random traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      if (!wr_req && $urandom_range(0, 3) == 0)
        start_wr(1'($urandom), 16'($urandom), int'($urandom_range(1, 3)));
      if (!rd_req && $urandom_range(0, 3) == 0)
        start_rd(1'($urandom), int'($urandom_range(1, 3)));
      if ($urandom_range(0, 99) == 0 && cyc != m_wack) begin
        async_reset();
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Arbitrates one single-port, 16-bit block RAM between two requesters.
- The write requester is the DHT11 capture path, which stores the packed humidity/temperature word.
- The read requester is the output path (UART/LED display), which fetches the stored word.
- Sequences the RAM's registered-read timing so each requester sees a clean req/ack handshake, and prevents starvation with round-robin arbitration.

Parameters:
- DATA_W, 16, width of the RAM data word.
- ADDR_W, 1, width of the RAM address.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- wr_req  in  1  write request; held high until wr_ack is seen.
- wr_addr  in  ADDR_W  write address; stable while wr_req is high.
- wr_data  in  DATA_W  write data; stable while wr_req is high.
- wr_ack  out  1  one-cycle pulse; the write was issued to the RAM.
- rd_req  in  1  read request; held high until rd_ack is seen.
- rd_addr  in  ADDR_W  read address; stable while rd_req is high.
- rd_ack  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  DATA_W  read result; held until the next read completes.
- bram_we  out  1  RAM write enable.
- bram_addr  out  ADDR_W  RAM address.
- bram_din  out  DATA_W  RAM write data.
- bram_dout  in  DATA_W  RAM registered read data, valid 1 cycle after the address is presented.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- All outputs are registered.
- Reset values: wr_ack=0, rd_ack=0, rd_data=0, bram_we=0, bram_addr=0, bram_din=0, busy=0, state=IDLE, last_grant=READ (so the writer wins the first contention).
- FSM states: IDLE, WR, RD_ADDR, RD_WAIT, RD_DONE.
- IDLE:
  - Requests are sampled at the clock edge.
  - Only wr_req -> WR. Only rd_req -> RD_ADDR.
  - Both high -> grant the side opposite last_grant, then update last_grant.
  - Neither -> stay in IDLE.
- WR (1 cycle): bram_we=1, bram_addr=wr_addr, bram_din=wr_data, wr_ack=1 -> IDLE.
- RD_ADDR (1 cycle): bram_we=0, bram_addr=rd_addr -> RD_WAIT.
- RD_WAIT (1 cycle): bram_dout is valid; capture it into rd_data at the closing edge -> RD_DONE.
- RD_DONE (1 cycle): rd_ack=1, rd_data holds the new value -> IDLE.
- bram_we is high only in WR and 0 in every other state.
- bram_addr and bram_din hold their last values outside WR/RD_ADDR.
- Latency, with the request first seen high at the edge ending cycle T:
  - write: wr_ack high in cycle T+1; RAM contents updated at the edge ending T+1.
  - read: rd_ack and rd_data high/valid in cycle T+3.
- Handshake:
  - The requester deasserts req in the cycle after it samples ack high.
  - A req still high in the first IDLE cycle after its ack is treated as a new request (back-to-back transfers).
  - Throughput: one write per 2 cycles, one read per 4 cycles.
  - Address and data are sampled on grant, i.e. the WR/RD_ADDR cycle. Changing them while req is high is illegal and gives undefined results.
- Read-after-write: if both requesters target the same address, order follows the grant. A read granted after a write returns the new data, because the RAM write completes before RD_ADDR.
- Starvation: with both requests held continuously, grants alternate W, R, W, R…. Neither side waits more than one transaction of the other.
- Only one ack is ever high in a given cycle.
- Reset mid-operation, in any state:
  - All outputs return to their reset values immediately (asynchronously).
  - An in-flight write may or may not have reached the RAM; no ack is generated for it.
  - An in-flight read is discarded and rd_data becomes 0.
  - Requesters re-request after reset releases.
- Reset release: the first grant can occur at the first clock edge where rst is low.

Test Plan:
- Write only: after reset, wr_req=1, wr_addr=0, wr_data=0x3A19 -> bram_we=1 with bram_din=0x3A19 and wr_ack=1 in the cycle after the request is sampled. A subsequent read returns 0x3A19 with rd_ack 3 cycles after its request.
- Read-only latency: RAM preloaded with 0x1234, rd_req at cycle 0 -> bram_addr=0 in cycle 1, rd_ack=1 and rd_data=0x1234 in cycle 3, busy high in cycles 1-3. rd_data holds 0x1234 after rd_req drops.
- Simultaneous requests after reset: wr_req and rd_req both high at the same edge, wr_data=0x5501 -> write is granted first (wr_ack at +1), then the read (rd_ack later) returns 0x5501. The two acks never overlap.
- Continuous contention: both reqs held for 20 cycles, wr_data incrementing on each wr_ack -> grant order W,R,W,R…, 3 writes and 3 reads complete, each read returns the value of the immediately preceding write.
- Reset mid-read: assert rst during RD_WAIT -> rd_ack never pulses, rd_data=0 and bram_we=0 within the same cycle, state is IDLE. A re-issued read after release completes normally.
- Back-to-back writes: wr_req held high for 8 cycles -> 4 wr_ack pulses on alternate cycles, bram_we never high in two consecutive cycles.
